vga_timing: RTL and testbench

// - Source end of the vga_if pixel stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk for every pixel clock.
// - Head of the draw pipeline. Feeds draw_bg and the later draw stages through vga_if.out.
// - rgb is driven black. Drawing stages overwrite it.
// - Also emits single-cycle frame_start and line_start strobes for the game logic.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 91 +++++++++
 tb/tb_vga_timing.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for 800x600@60 (40 MHz pixel clock) and a window-decode helper.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned H_FP_LEN   = 40;
  localparam int unsigned H_SYNC_LEN = 128;
  localparam int unsigned H_BP_LEN   = 88;
  localparam int unsigned HOR_TOTAL  = HOR_PIXELS + H_FP_LEN + H_SYNC_LEN + H_BP_LEN;

  localparam int unsigned VER_PIXELS = 600;
  localparam int unsigned V_FP_LEN   = 1;
  localparam int unsigned V_SYNC_LEN = 4;
  localparam int unsigned V_BP_LEN   = 23;
  localparam int unsigned VER_TOTAL  = VER_PIXELS + V_FP_LEN + V_SYNC_LEN + V_BP_LEN;

  localparam int unsigned COUNT_W = 11;
  localparam int unsigned COUNT_MAX = (1 << COUNT_W) - 1;

  typedef logic [COUNT_W-1:0] count_t;

  // True when c lies in the half-open window [lo, lo+len).
  function automatic logic in_window(count_t c, int unsigned lo, int unsigned len);
    return (32'(c) >= lo) && (32'(c) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: registered counters, syncs, blanks and frame/line strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HOR_PIXELS,
  parameter int unsigned H_FP     = H_FP_LEN,
  parameter int unsigned H_SYNC   = H_SYNC_LEN,
  parameter int unsigned H_BP     = H_BP_LEN,
  parameter int unsigned V_ACTIVE = VER_PIXELS,
  parameter int unsigned V_FP     = V_FP_LEN,
  parameter int unsigned V_SYNC   = V_SYNC_LEN,
  parameter int unsigned V_BP     = V_BP_LEN
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX) begin : gen_total_chk
    $error("vga_timing: H_TOTAL or V_TOTAL exceeds 11-bit counter range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : gen_len_chk
    $error("vga_timing: porch and sync lengths must be nonzero");
  end

  // Low while the outputs still show the reset value; the next pixel is then (0,0).
  logic   started_q;
  count_t hcount_d, vcount_d;
  logic   hsync_d, hblnk_d, vsync_d, vblnk_d, frame_start_d, line_start_d;

  always_comb begin
    hcount_d = '0;
    vcount_d = '0;
    if (started_q) begin
      if (hcount == count_t'(H_TOTAL - 1)) begin
        vcount_d = (vcount == count_t'(V_TOTAL - 1)) ? '0 : vcount + count_t'(1);
      end else begin
        hcount_d = hcount + count_t'(1);
        vcount_d = vcount;
      end
    end
  end

  // Decode from the next-state counters so the registered decodes align with the counts.
  always_comb begin
    hblnk_d       = 32'(hcount_d) >= H_ACTIVE;
    hsync_d       = in_window(hcount_d, H_ACTIVE + H_FP, H_SYNC);
    vblnk_d       = 32'(vcount_d) >= V_ACTIVE;
    vsync_d       = in_window(vcount_d, V_ACTIVE + V_FP, V_SYNC);
    line_start_d  = hcount_d == '0;
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    rgb <= '0;
    if (rst) begin
      started_q   <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      started_q   <= 1'b1;
      hcount      <= hcount_d;
      vcount      <= vcount_d;
      hsync       <= hsync_d;
      hblnk       <= hblnk_d;
      vsync       <= vsync_d;
      vblnk       <= vblnk_d;
      frame_start <= frame_start_d;
      line_start  <= line_start_d;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a reduced-timing instance checked per cycle, plus a default-timing instance.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int unsigned HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int unsigned VA = 12, VF = 1, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] vcount, hcount, vcount_f, hcount_f;
  logic        vsync, vblnk, hsync, hblnk, frame_start, line_start;
  logic        vsync_f, vblnk_f, hsync_f, hblnk_f, frame_start_f, line_start_f;
  logic [11:0] rgb, rgb_f;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .vcount(vcount), .vsync(vsync), .vblnk(vblnk), .hcount(hcount),
    .hsync(hsync), .hblnk(hblnk), .rgb(rgb), .frame_start(frame_start), .line_start(line_start)
  );

  vga_timing dut_full (
    .clk(clk), .rst(rst), .vcount(vcount_f), .vsync(vsync_f), .vblnk(vblnk_f),
    .hcount(hcount_f), .hsync(hsync_f), .hblnk(hblnk_f), .rgb(rgb_f),
    .frame_start(frame_start_f), .line_start(line_start_f)
  );

  always #5 clk = ~clk;

  logic [39:0] obs, obs_f;
  assign obs   = {vcount, vsync, vblnk, hcount, hsync, hblnk, rgb, frame_start, line_start};
  assign obs_f = {vcount_f, vsync_f, vblnk_f, hcount_f, hsync_f, hblnk_f, rgb_f, frame_start_f,
                  line_start_f};

  int vectors = 0;
  int miscompares = 0;
  int pix = -1;  // pixels presented since reset release; -1 means outputs show reset value

  // Raster position from the pixel index by plain division, decodes from the window rules.
  function automatic logic [39:0] model(int n, int unsigned ha, int unsigned hf, int unsigned hs,
                                        int unsigned hb, int unsigned va, int unsigned vf,
                                        int unsigned vs, int unsigned vb);
    int unsigned ht, vt, hc, vc, u;
    if (n < 0) return '0;
    u  = n;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    hc = u % ht;
    vc = (u / ht) % vt;
    return {11'(vc), (vc >= va + vf) && (vc < va + vf + vs), vc >= va,
            11'(hc), (hc >= ha + hf) && (hc < ha + hf + hs), hc >= ha,
            12'h000, (hc == 0) && (vc == 0), hc == 0};
  endfunction

  function automatic logic [39:0] small_model(int n);
    return model(n, HA, HF, HS, HB, VA, VF, VS, VB);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) pix = -1;
    else pix++;
    #1;
  endtask

  task automatic test_reset();
    logic [39:0] exp0;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (obs !== 40'h0) begin
      $display("FAIL reset_state: got %h want %h", obs, 40'h0);
      miscompares++;
    end
    rst = 1'b0;
    tick();
    exp0 = {11'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    vectors++;
    if (obs !== exp0) begin
      $display("FAIL first_pixel: got %h want %h", obs, exp0);
      miscompares++;
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    int rise_at = -1;
    logic prev_hblnk = hblnk;
    for (int i = 0; i < int'(HT); i++) begin
      tick();
      vectors++;
      if (obs !== small_model(pix)) begin
        $display("FAIL line_pixel: pix %0d got %h want %h", pix, obs, small_model(pix));
        miscompares++;
      end
      if (hsync) hs_cnt++;
      if (hblnk && !prev_hblnk && rise_at < 0) rise_at = int'(hcount);
      prev_hblnk = hblnk;
    end
    vectors++;
    if (hs_cnt != int'(HS)) begin
      $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS);
      miscompares++;
    end
    vectors++;
    if (rise_at != int'(HA)) begin
      $display("FAIL hblnk_rise: got %0d want %0d", rise_at, HA);
      miscompares++;
    end
    vectors++;
    if (hcount !== 11'd0 || vcount !== 11'd1) begin
      $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", hcount, vcount);
      miscompares++;
    end
  endtask

  task automatic test_frame();
    int cycles = 0;
    int vs_cnt = 0;
    int vb_rise = -1;
    logic prev_vblnk;
    while (!frame_start && cycles <= int'(2 * FRAME)) begin
      tick();
      cycles++;
    end
    cycles = 0;
    prev_vblnk = vblnk;
    do begin
      tick();
      cycles++;
      vectors++;
      if (obs !== small_model(pix)) begin
        $display("FAIL frame_pixel: pix %0d got %h want %h", pix, obs, small_model(pix));
        miscompares++;
      end
      if (vsync) vs_cnt++;
      if (vblnk && !prev_vblnk && vb_rise < 0) vb_rise = int'(vcount);
      prev_vblnk = vblnk;
    end while (!frame_start && cycles <= int'(2 * FRAME));
    vectors++;
    if (cycles != int'(FRAME)) begin
      $display("FAIL frame_period: got %0d want %0d", cycles, FRAME);
      miscompares++;
    end
    vectors++;
    if (vs_cnt != int'(VS * HT)) begin
      $display("FAIL vsync_width: got %0d want %0d", vs_cnt, VS * HT);
      miscompares++;
    end
    vectors++;
    if (vb_rise != int'(VA)) begin
      $display("FAIL vblnk_rise: got %0d want %0d", vb_rise, VA);
      miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    logic [39:0] exp0;
    while (!(hcount == 11'd13 && vcount == 11'd7) && guard <= int'(FRAME)) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard > int'(FRAME)) begin
      $display("FAIL mid_reset_reach: got timeout want h=13 v=7");
      miscompares++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (obs !== 40'h0) begin
      $display("FAIL mid_reset_zero: got %h want %h", obs, 40'h0);
      miscompares++;
    end
    tick();
    exp0 = {11'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    vectors++;
    if (obs !== exp0) begin
      $display("FAIL mid_reset_restart: got %h want %h", obs, exp0);
      miscompares++;
    end
  endtask

  // Starts from a presented (0,0) pixel and covers exactly two frames.
  task automatic test_two_frames();
    int fs = 0, ls = 0, rgb_bad = 0, edge_bad = 0;
    logic pvs, pvb;
    if (frame_start) fs++;
    if (line_start) ls++;
    pvs = vsync;
    pvb = vblnk;
    for (int i = 1; i < int'(2 * FRAME); i++) begin
      tick();
      if (frame_start) fs++;
      if (line_start) ls++;
      if (rgb !== 12'h000) rgb_bad++;
      if ((vsync !== pvs || vblnk !== pvb) && hcount !== 11'd0) edge_bad++;
      pvs = vsync;
      pvb = vblnk;
    end
    vectors++;
    if (fs != 2) begin
      $display("FAIL frame_start_count: got %0d want 2", fs);
      miscompares++;
    end
    vectors++;
    if (ls != int'(2 * VT)) begin
      $display("FAIL line_start_count: got %0d want %0d", ls, 2 * VT);
      miscompares++;
    end
    vectors++;
    if (rgb_bad != 0) begin
      $display("FAIL rgb_black: got %0d nonzero cycles want 0", rgb_bad);
      miscompares++;
    end
    vectors++;
    if (edge_bad != 0) begin
      $display("FAIL vertical_edges: got %0d mid-line edges want 0", edge_bad);
      miscompares++;
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 15; it++) begin
      int run = $urandom_range(1, 700);
      int hold = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) begin
        tick();
        vectors++;
        if (obs !== small_model(pix)) begin
          $display("FAIL random_run: pix %0d got %h want %h", pix, obs, small_model(pix));
          miscompares++;
        end
      end
      rst = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        vectors++;
        if (obs !== 40'h0) begin
          $display("FAIL random_reset: got %h want %h", obs, 40'h0);
          miscompares++;
        end
      end
      rst = 1'b0;
    end
  endtask

  task automatic test_full_timing();
    logic [39:0] exp;
    int bad = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      exp = model(pix, HOR_PIXELS, H_FP_LEN, H_SYNC_LEN, H_BP_LEN,
                  VER_PIXELS, V_FP_LEN, V_SYNC_LEN, V_BP_LEN);
      if (obs_f !== exp) begin
        if (bad < 5) $display("FAIL full_timing: pix %0d got %h want %h", pix, obs_f, exp);
        bad++;
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_two_frames();
    test_random_resets();
    test_full_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
